// File: rtl/uart_fifo_bridge.sv
// UART RX -> FIFO -> UART TX bridge on one clock; a good byte is pushed on its RX stop sample and popped when TX is idle.
// Backpressure: tx_pause holds frames in the FIFO; a good frame arriving with the FIFO full is dropped and flags overflow.
module uart_fifo_bridge #(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int DIV_WIDTH       = 16,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIV_WIDTH-1:0]       baud_div,
  input  logic                       uart_rx,
  input  logic                       tx_pause,
  input  logic                       err_clr,
  output logic                       uart_tx,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
  output logic                       overflow,
  output logic                       frame_err,
  output logic                       parity_err
);
  localparam int   DW        = DATA_WIDTH;
  localparam int   AW        = FIFO_ADDR_WIDTH;
  localparam logic P_EN      = (PARITY_EN != 0);
  localparam logic P_ODD     = (PARITY_ODD != 0);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic [3:0] BIT_LAST = 4'(DW - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // Divisor is reloaded only on wrap so a change never truncates the current period.
  logic [DIV_WIDTH-1:0] r_tick_cnt, r_div;
  logic w_tick;
  assign w_tick = (r_tick_cnt == r_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_div      <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_div      <= baud_div;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  rx_state_t r_rx_state, w_rx_next;
  logic          r_rx_s1, r_rx_s2, r_rx_par;
  logic [3:0]    r_rx_tcnt, r_rx_bcnt;
  logic [DW-1:0] r_rx_shift;
  logic w_rx_bit, w_rx_mid, w_rx_sample, w_stop_evt, w_par_bad;
  logic w_fe_evt, w_pe_evt, w_ov_evt, w_push, w_pop, w_full, w_empty;

  assign w_rx_bit    = r_rx_s2;
  assign w_rx_mid    = w_tick && (r_rx_tcnt == 4'd7);
  assign w_rx_sample = w_tick && (r_rx_tcnt == 4'd15);
  assign w_stop_evt  = (r_rx_state == RX_STOP) && w_rx_sample;
  assign w_par_bad   = P_EN & ((^r_rx_shift) ^ r_rx_par ^ P_ODD);
  assign w_fe_evt    = w_stop_evt & ~w_rx_bit;
  assign w_pe_evt    = w_stop_evt & w_rx_bit & w_par_bad;
  assign w_ov_evt    = w_stop_evt & w_rx_bit & ~w_par_bad & w_full;
  assign w_push      = w_stop_evt & w_rx_bit & ~w_par_bad & ~w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
    end else begin
      r_rx_state <= w_rx_next;
      r_rx_s1    <= uart_rx;
      r_rx_s2    <= r_rx_s1;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (w_tick && !w_rx_bit) w_rx_next = RX_START;
      RX_START:  if (w_rx_mid) w_rx_next = w_rx_bit ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_rx_sample && r_rx_bcnt == BIT_LAST) w_rx_next = P_EN ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_sample) w_rx_next = RX_STOP;
      RX_STOP:   if (w_rx_sample) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_shift <= '0;
      r_rx_par   <= 1'b0;
    end else begin
      if (r_rx_state != w_rx_next) r_rx_tcnt <= '0;
      else if (w_tick)             r_rx_tcnt <= r_rx_tcnt + 1'b1;
      if (r_rx_state == RX_START) begin
        r_rx_bcnt <= '0;
      end else if (r_rx_state == RX_DATA && w_rx_sample) begin
        r_rx_bcnt  <= r_rx_bcnt + 1'b1;
        r_rx_shift <= {w_rx_bit, r_rx_shift[DW-1:1]};
      end
      if (r_rx_state == RX_PARITY && w_rx_sample) r_rx_par <= w_rx_bit;
    end
  end

  // Pointers carry a wrap bit so full and empty are distinguishable by subtraction.
  logic [DW-1:0] r_mem [0:(2**AW)-1];
  logic [DW-1:0] r_rd_dat;
  logic [AW:0]   r_wr_ptr, r_rd_ptr, w_level;
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_full     = w_level[AW];
  assign w_empty    = (w_level == '0);
  assign fifo_level = w_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_rx_shift;
    if (w_pop)  r_rd_dat <= r_mem[r_rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  tx_state_t r_tx_state, w_tx_next;
  logic [3:0]    r_tx_tcnt, r_tx_bcnt;
  logic          r_tx_scnt, r_tx_par, w_tx_end, w_tx_bit;
  logic [DW-1:0] r_tx_shift;
  assign w_pop    = (r_tx_state == TX_IDLE) && !w_empty && !tx_pause;
  assign w_tx_end = w_tick && (r_tx_tcnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_bit  = 1'b1;
    case (r_tx_state)
      TX_IDLE:   if (w_pop) w_tx_next = TX_LOAD;
      TX_LOAD:   if (w_tick) w_tx_next = TX_START;
      TX_START: begin
        w_tx_bit = 1'b0;
        if (w_tx_end) w_tx_next = TX_DATA;
      end
      TX_DATA: begin
        w_tx_bit = r_tx_shift[0];
        if (w_tx_end && r_tx_bcnt == BIT_LAST) w_tx_next = P_EN ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        w_tx_bit = r_tx_par;
        if (w_tx_end) w_tx_next = TX_STOP;
      end
      TX_STOP:   if (w_tx_end && r_tx_scnt == STOP_LAST) w_tx_next = TX_IDLE;
      default:   w_tx_next = TX_IDLE;
    endcase
  end
  assign uart_tx = w_tx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_tcnt  <= '0;
      r_tx_bcnt  <= '0;
      r_tx_scnt  <= 1'b0;
      r_tx_par   <= 1'b0;
      r_tx_shift <= '0;
    end else begin
      if (r_tx_state != w_tx_next) r_tx_tcnt <= '0;
      else if (w_tick)             r_tx_tcnt <= r_tx_tcnt + 1'b1;
      if (r_tx_state == TX_LOAD) begin
        r_tx_shift <= r_rd_dat;
        r_tx_par   <= (^r_rd_dat) ^ P_ODD;
        r_tx_bcnt  <= '0;
        r_tx_scnt  <= 1'b0;
      end else if (r_tx_state == TX_DATA && w_tx_end) begin
        r_tx_shift <= {1'b0, r_tx_shift[DW-1:1]};
        r_tx_bcnt  <= r_tx_bcnt + 1'b1;
      end else if (r_tx_state == TX_STOP && w_tx_end) begin
        r_tx_scnt  <= 1'b1;
      end
    end
  end

  logic r_overflow, r_frame_err, r_parity_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_overflow   <= (r_overflow   & ~err_clr) | w_ov_evt;
      r_frame_err  <= (r_frame_err  & ~err_clr) | w_fe_evt;
      r_parity_err <= (r_parity_err & ~err_clr) | w_pe_evt;
    end
  end
  assign overflow   = r_overflow;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: an 8N1 instance and an even-parity instance share clock, reset and baud_div=3.
// A frame monitor decodes the OR-idle TX lines and checks them against a queue of expected bytes.
module tb_uart_fifo_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        rx0 = 1'b1, rx1 = 1'b1, tx_pause = 1'b0, err_clr = 1'b0;
  logic        tx0, tx1, ov0, fe0, pe0, ov1, fe1, pe1;
  logic [4:0]  lvl0, lvl1;

  int   tests = 0, fails = 0, cyc = 0;
  int   lvl1_cnt = 0, tx_low_cnt = 0;
  bit   mon_en = 1'b1, mon_par = 1'b0, mon_busy = 1'b0;
  logic [8:0] exp_q[$];
  wire  mon_line = tx0 & tx1;

  typedef struct {
    logic [7:0] d;
    bit         stop_b;
    bit         exp_fe;
  } vec_t;
  vec_t tbl[5];
  int   exp_iv[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_fifo_bridge u_dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .uart_rx(rx0), .tx_pause(tx_pause),
    .err_clr(err_clr), .uart_tx(tx0), .fifo_level(lvl0), .overflow(ov0),
    .frame_err(fe0), .parity_err(pe0)
  );

  uart_fifo_bridge #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
    .clk(clk), .rst(rst), .baud_div(baud_div), .uart_rx(rx1), .tx_pause(tx_pause),
    .err_clr(err_clr), .uart_tx(tx1), .fifo_level(lvl1), .overflow(ov1),
    .frame_err(fe1), .parity_err(pe1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit use_par, input bit p, input bit stop_b);
    @(negedge clk);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, p);
    drive_bit(sel, stop_b);
    if (!stop_b) drive_bit(sel, 1'b1);
  endtask

  task automatic wait_tx(input logic v, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (tx0 == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int maxc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy && lvl0 == 5'd0 && lvl1 == 5'd0 && tx0 && tx1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", int'(ok), 1);
    repeat (100) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic monitor();
    logic [8:0] got, e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && !mon_line) begin
        mon_busy = 1'b1;
        got = '0;
        repeat (31) @(negedge clk);
        chk("mon_start_bit", int'(mon_line), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (64) @(negedge clk);
          got[i] = mon_line;
        end
        if (mon_par) begin
          repeat (64) @(negedge clk);
          got[8] = mon_line;
        end
        repeat (64) @(negedge clk);
        chk("mon_stop_bit", int'(mon_line), 1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL mon_unexpected_frame: got 0x%0h, required no frame", got);
        end else begin
          e = exp_q.pop_front();
          chk("mon_frame_data", int'(got), int'(e));
        end
        mon_busy = 1'b0;
      end
    end
  endtask

  task automatic watch();
    forever begin
      @(negedge clk);
      if (lvl0 == 5'd1) lvl1_cnt++;
      if (!rst && !mon_line) tx_low_cnt++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t_prev, lvl1_before;
    logic v;

    tbl[0] = '{d: 8'h3C, stop_b: 1'b0, exp_fe: 1'b1};
    tbl[1] = '{d: 8'h00, stop_b: 1'b1, exp_fe: 1'b0};
    tbl[2] = '{d: 8'hFF, stop_b: 1'b1, exp_fe: 1'b0};
    tbl[3] = '{d: 8'h5A, stop_b: 1'b0, exp_fe: 1'b1};
    tbl[4] = '{d: 8'h81, stop_b: 1'b1, exp_fe: 1'b0};
    exp_iv = '{64, 64, 64, 64, 128, 64, 64};

    fork
      monitor();
      watch();
    join_none

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_uart_tx", int'(tx0), 1);
    chk("rst_level", int'(lvl0), 0);
    chk("rst_flags", int'({ov0, fe0, pe0}), 0);
    chk("rst_par_tx", int'(tx1), 1);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 0xA5 loopback with bit timing
    lvl1_before = lvl1_cnt;
    exp_q.push_back(9'h0A5);
    fork
      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        wait_tx(1'b0, 2000, ok);
        chk("a5_tx_start_seen", int'(ok), 1);
        t_prev = cyc;
        v = 1'b0;
        for (int k = 0; k < 7; k++) begin
          v = ~v;
          wait_tx(v, 400, ok);
          chk_rng("a5_bit_time", cyc - t_prev, exp_iv[k] - 4, exp_iv[k] + 4);
          t_prev = cyc;
        end
      end
    join
    wait_idle(3000);
    chk("a5_level_pulse", (lvl1_cnt > lvl1_before) ? 1 : 0, 1);
    chk("a5_flags", int'({ov0, fe0, pe0}), 0);

    // Table: good frames loop back, stop-low frames set frame_err and are dropped
    for (int i = 0; i < 5; i++) begin
      if (!tbl[i].exp_fe) exp_q.push_back({1'b0, tbl[i].d});
      send(1'b0, tbl[i].d, 1'b0, 1'b0, tbl[i].stop_b);
      chk("tbl_frame_err", int'(fe0), int'(tbl[i].exp_fe));
      chk("tbl_ovf_par", int'({ov0, pe0}), 0);
      wait_idle(3000);
      chk("tbl_level", int'(lvl0), 0);
      pulse_clr();
      chk("tbl_frame_err_clr", int'(fe0), 0);
    end

    // Fill while paused, overflow on the 17th byte, then drain in order
    tx_pause = 1'b1;
    for (int b = 0; b < 17; b++) begin
      if (b < 16) exp_q.push_back(9'(b));
      send(1'b0, 8'(b), 1'b0, 1'b0, 1'b1);
    end
    chk("full_level", int'(lvl0), 16);
    chk("full_overflow", int'(ov0), 1);
    chk("full_frame_err", int'(fe0), 0);
    tx_pause = 1'b0;
    wait_idle(20000);
    chk("drain_level", int'(lvl0), 0);
    chk("drain_overflow_sticky", int'(ov0), 1);
    pulse_clr();
    chk("overflow_clr", int'(ov0), 0);

    // Even parity: 0x07 needs parity bit 1
    mon_par = 1'b1;
    send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    chk("par_bad_flag", int'(pe1), 1);
    chk("par_bad_level", int'(lvl1), 0);
    chk("par_bad_frame_err", int'(fe1), 0);
    pulse_clr();
    chk("par_clr", int'(pe1), 0);
    exp_q.push_back(9'h107);
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("par_good_flag", int'(pe1), 0);
    wait_idle(3000);
    mon_par = 1'b0;

    // 20-clock glitch is rejected
    tx_low_cnt = 0;
    @(negedge clk) rx0 = 1'b0;
    repeat (20) @(negedge clk);
    rx0 = 1'b1;
    repeat (2000) @(negedge clk);
    chk("glitch_level", int'(lvl0), 0);
    chk("glitch_flags", int'({ov0, fe0, pe0}), 0);
    chk("glitch_tx_idle", tx_low_cnt, 0);

    // Reset during the 4th TX data bit of 0x55 (bit3 = 0)
    mon_en = 1'b0;
    fork
      send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      begin
        wait_tx(1'b0, 2000, ok);
        chk("rst_mid_start_seen", int'(ok), 1);
        repeat (64 + 3 * 64 + 32 - 1) @(negedge clk);
        chk("rst_mid_tx_before", int'(tx0), 0);
        #2 rst = 1'b1;
        #1 chk("rst_mid_tx_now", int'(tx0), 1);
      end
    join
    repeat (5) @(negedge clk);
    rst = 1'b0;
    tx_low_cnt = 0;
    mon_en = 1'b1;
    repeat (2000) @(negedge clk);
    chk("rst_mid_level", int'(lvl0), 0);
    chk("rst_mid_no_output", tx_low_cnt, 0);
    chk("rst_mid_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
